alu_multiply_sequencer: RTL and testbench

Multi-cycle controller that performs an unsigned 32x32->32 multiply by sequencing the shared 32-bit ALU through shift-and-add steps. It owns the ALU's A, B, FunSel and WF inputs while busy, and reads ALUOut and FlagsOut back. It produces the low 32 product bits plus an exact unsigned-overflow flag. Requesters use a Start/Done handshake.

---
 rtl/alu_multiply_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_multiply_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_multiply_sequencer.sv
// Unsigned WIDTHxWIDTH -> WIDTH multiply by sequencing a shared ALU through
// shift-and-add steps, with an exact unsigned-overflow flag.
module alu_multiply_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product,
  output logic             o_ovf,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [4:0]       o_alu_funsel,
  output logic             o_alu_wf,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic [3:0]       i_alu_flags
);

  localparam logic [4:0] FS_IDLE = 5'b10000;
  localparam logic [4:0] FS_ADD  = 5'b10100;
  localparam logic [4:0] FS_LSL  = 5'b11011;
  localparam int unsigned FLAG_C = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_lost;
  logic             r_ovf;
  logic             r_prev_add;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [4:0]       r_alu_funsel;
  logic             r_alu_wf;

  // ALU drive is registered alongside the state it belongs to, so each
  // transition loads the drive for the state being entered.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_p          <= '0;
      r_m          <= '0;
      r_q          <= '0;
      r_lost       <= 1'b0;
      r_ovf        <= 1'b0;
      r_prev_add   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_funsel <= FS_IDLE;
      r_alu_wf     <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_prev_add   <= (r_state == S_ADD);
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_funsel <= FS_IDLE;
      r_alu_wf     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_p     <= '0;
            r_m     <= i_op_a;
            r_q     <= i_op_b;
            r_lost  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (r_q == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_q[0]) begin
            r_alu_a      <= r_p;
            r_alu_b      <= r_m;
            r_alu_funsel <= FS_ADD;
            r_alu_wf     <= 1'b1;
            r_state      <= S_ADD;
          end else begin
            r_alu_a      <= r_m;
            r_alu_funsel <= FS_LSL;
            r_state      <= S_SHIFT;
          end
        end
        S_ADD: begin
          r_p <= i_alu_out;
          // Adding a multiplicand that already lost high bits means the true sum overflowed.
          if (r_lost) r_ovf <= 1'b1;
          r_alu_a      <= r_m;
          r_alu_funsel <= FS_LSL;
          r_state      <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_prev_add && i_alu_flags[FLAG_C]) r_ovf <= 1'b1;
          if (r_m[WIDTH-1]) r_lost <= 1'b1;
          r_m     <= i_alu_out;
          r_q     <= r_q >> 1;
          r_state <= S_EVAL;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_product    = r_p;
  assign o_ovf        = r_ovf;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_funsel = r_alu_funsel;
  assign o_alu_wf     = r_alu_wf;

endmodule

// File: tb/tb_alu_multiply_sequencer.sv
// Directed bench for alu_multiply_sequencer with a small behavioural ALU model.
module tb_alu_multiply_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam logic [4:0] FS_IDLE = 5'b10000;
  localparam logic [4:0] FS_ADD  = 5'b10100;
  localparam logic [4:0] FS_LSL  = 5'b11011;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             ovf;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_funsel;
  logic             alu_wf;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_flags = 4'b0000;
  logic [WIDTH:0]   alu_sum;

  int total = 0;
  int bad   = 0;

  alu_multiply_sequencer #(.WIDTH(WIDTH)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_op_a       (op_a),
    .i_op_b       (op_b),
    .o_busy       (busy),
    .o_done       (done),
    .o_product    (product),
    .o_ovf        (ovf),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_funsel (alu_funsel),
    .o_alu_wf     (alu_wf),
    .i_alu_out    (alu_out),
    .i_alu_flags  (alu_flags)
  );

  always #5 clk = ~clk;

  // Shared ALU: combinational result, flags {Z,C,N,O} latched when WF is set.
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_funsel)
      FS_ADD:  alu_out = alu_sum[WIDTH-1:0];
      FS_LSL:  alu_out = alu_a << 1;
      default: alu_out = alu_a;
    endcase
  end

  always @(posedge clk) begin
    if (alu_wf)
      alu_flags <= {alu_out == '0, alu_sum[WIDTH], alu_out[WIDTH-1], 1'b0};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one multiply; optionally re-pulses Start with 9*9 mid-operation.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_p, input logic exp_ovf,
                        input int exp_lat, input int exp_adds, input int exp_shifts,
                        input bit repulse);
    int lat;
    int adds;
    int shifts;
    lat = 0; adds = 0; shifts = 0;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && lat < 200) begin
      if (repulse && lat == 3) begin
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (alu_funsel == FS_ADD) begin
        adds++;
        check({tag, " add_wf"}, 64'(alu_wf), 64'd1);
      end
      if (alu_funsel == FS_LSL) shifts++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " product"}, 64'(product), 64'(exp_p));
    check({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
    check({tag, " busy_in_done"}, 64'(busy), 64'd0);
    check({tag, " adds"}, 64'(adds), 64'(exp_adds));
    check({tag, " shifts"}, 64'(shifts), 64'(exp_shifts));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " product_hold"}, 64'(product), 64'(exp_p));
  endtask

  initial begin
    rst = 1'b1;
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst product", 64'(product), 64'd0);
    check("rst ovf", 64'(ovf), 64'd0);
    check("rst funsel", 64'(alu_funsel), 64'(FS_IDLE));
    check("rst wf", 64'(alu_wf), 64'd0);
    check("rst alu_a", 64'(alu_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("6x7",      32'd6,          32'd7,       32'd42,         1'b0, 10, 3, 3, 1'b0);
    run_op("5x0",      32'd5,          32'd0,       32'd0,          1'b0,  1, 0, 0, 1'b0);
    run_op("ffx2",     32'hFFFF_FFFF,  32'd2,       32'hFFFF_FFFE,  1'b1,  6, 1, 2, 1'b0);
    run_op("ffx3",     32'hFFFF_FFFF,  32'd3,       32'hFFFF_FFFD,  1'b1,  7, 2, 2, 1'b0);
    run_op("carry",    32'h6000_0000,  32'd3,       32'h2000_0000,  1'b1,  7, 2, 2, 1'b0);
    run_op("64kx64k",  32'h0001_0000,  32'h0001_0000, 32'd0,        1'b1, 36, 1, 17, 1'b0);
    run_op("repulse",  32'd6,          32'd7,       32'd42,         1'b0, 10, 3, 3, 1'b1);
    run_op("9x9",      32'd9,          32'd9,       32'd81,         1'b0, 11, 2, 4, 1'b0);

    // Abort 6*7 in its third cycle after the accepting edge.
    @(negedge clk);
    start = 1'b1; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("pre_abort product", 64'(product), 64'd6);
    rst = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort product", 64'(product), 64'd0);
    check("abort ovf", 64'(ovf), 64'd0);
    check("abort wf", 64'(alu_wf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_abort done", 64'(done), 64'd0);

    run_op("3x4",      32'd3,          32'd4,       32'd12,         1'b0,  8, 1, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
